// File: rtl/data_mem_responder.sv
// data_mem_responder: single-initiator data memory responder for an RV32I core.
// One request is in flight at a time. It serves byte, halfword and word loads
// and stores to a synchronous-read RAM, plus two MMIO words: an output register
// (led/red/green/blue) and a free-running cycle counter.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we, req_funct3   store/load select; RV32I size/sign encoding
//   req_addr, req_wdata  byte address; right-justified store data
//   resp_valid/ready     response handshake
//   resp_rdata, resp_err extended load data (0 for stores/errors); fault flag
//   led, red, green, blue   output register bits 0..3
module data_mem_responder #(
  parameter int unsigned RAM_WORDS = 2048,
  parameter logic [31:0] RAM_BASE  = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned AW       = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_MASK = ~(32'(RAM_WORDS * 4) - 32'd1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0] mem [RAM_WORDS];
  logic [31:0] rd_q;
  logic [31:0] wbuf_q;
  logic [AW-1:0] idx_q;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [15:0] wdata_q;

  logic [31:0] rdata_q;
  logic        err_q;
  logic [3:0]  out_q;
  logic [31:0] cnt_q;

  logic        accept;
  logic        f3_ok, misalign, hit_ram, hit_out, hit_cnt, dec_err;
  logic [31:0] mmio_word;
  logic [31:0] req_off;
  logic [AW-1:0] req_idx;
  logic        unused_off;
  logic        ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0] ram_wdata;

  // Pick the addressed lane and apply sign/zero extension for the load size.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  f3);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Replace only the byte/halfword lane addressed by the store.
  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [15:0] wd,
                                              input logic [1:0]  lane,
                                              input logic        half);
    logic [31:0] mask, data;
    if (half) begin
      mask = 32'h0000_FFFF << {lane, 3'b000};
      data = {2{wd}};
    end else begin
      mask = 32'h0000_00FF << {lane, 3'b000};
      data = {4{wd[7:0]}};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP) && !reset;
  assign resp_rdata = reset ? '0 : rdata_q;
  assign resp_err   = resp_valid && err_q;
  assign led        = out_q[0] && !reset;
  assign red        = out_q[1] && !reset;
  assign green      = out_q[2] && !reset;
  assign blue       = out_q[3] && !reset;

  assign req_off    = req_addr - RAM_BASE;
  assign req_idx    = req_off[AW+1:2];
  assign unused_off = &{1'b0, req_off[31:AW+2], req_off[1:0]};
  assign mmio_word  = hit_out ? {28'b0, out_q} : cnt_q;

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_we;
      default:                f3_ok = 1'b0;
    endcase
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    hit_ram  = (req_addr & RAM_MASK) == RAM_BASE;
    hit_out  = req_addr[31:2] == 30'h3FFF_FFFF;
    hit_cnt  = req_addr[31:2] == 30'h3FFF_FFFE;
    dec_err  = !f3_ok || misalign || !(hit_ram || hit_out || hit_cnt);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_err || !hit_ram)              state_d = RESP;
          else if (!req_we)                     state_d = RD_WAIT;
          else if (req_funct3[1:0] == 2'b10)    state_d = RESP;
          else                                  state_d = RMW_RD;
        end
      end
      RD_WAIT: state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Full-word stores write on the accept edge; sub-word stores write the
  // merged word from RMW_WR. Reset suppresses both, aborting a pending RMW.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = req_idx;
    ram_wdata = req_wdata;
    if (!reset) begin
      if (state_q == RMW_WR) begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        ram_wdata = wbuf_q;
      end else if (accept && !dec_err && hit_ram && req_we &&
                   (req_funct3[1:0] == 2'b10)) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rd_q <= mem[req_idx];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= req_idx;
      lane_q  <= req_addr[1:0];
      f3_q    <= req_funct3;
      wdata_q <= req_wdata[15:0];
    end
    if (state_q == RMW_RD) wbuf_q <= merge_store(rd_q, wdata_q, lane_q, f3_q[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            err_q   <= dec_err;
            rdata_q <= '0;
            if (!dec_err && !hit_ram) begin
              if (!req_we)
                rdata_q <= load_ext(mmio_word, req_addr[1:0], req_funct3);
              else if (hit_out && (req_addr[1:0] == 2'b00))
                out_q <= req_wdata[3:0];
            end
          end
        end
        RD_WAIT: rdata_q <= load_ext(rd_q, lane_q, f3_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder. The driver pushes the expected
// response (data, error, latency, accept cycle) into a queue at the accept;
// an independent monitor pops and compares at each response handshake.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        led, red, green, blue;

  data_mem_responder #(.RAM_WORDS(2048), .RAM_BASE(32'h0000_2000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int rel_cyc = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a request and hold it until accepted. cnt_model derives the
  // expected counter value from cycles elapsed since reset release.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                       input int lat, input bit push, input bit cnt_model);
    int n;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1 (addr %h)", addr);
      req_valid = 1'b0;
      return;
    end
    e.d = cnt_model ? 32'(cyc - rel_cyc) : exp_d;
    e.e = exp_e;
    e.lat = lat;
    e.acc = cyc;
    last_acc = cyc;
    if (push) sb_q.push_back(e);
    @(negedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: pending responses got %0d expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     input int lat);
    issue(we, f3, addr, wd, exp_d, exp_e, lat, 1'b1, 1'b0);
    drain();
  endtask

  // Monitor: samples after the driver's mid-cycle updates, before the next edge.
  initial begin
    exp_t e;
    logic prev_v;
    int rise;
    prev_v = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk); #2;
      if (resp_valid && !prev_v) rise = cyc;
      prev_v = resp_valid;
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
        end else begin
          e = sb_q.pop_front();
          check("rdata", resp_rdata, e.d);
          check("err", 32'(resp_err), 32'(e.e));
          check("latency", 32'(rise - e.acc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    int n;

    repeat (3) @(negedge clk);
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_leds", 32'({blue, green, red, led}), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    rel_cyc = cyc;
    @(negedge clk); #2;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // RAM word/byte/half traffic
    txn(1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    txn(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    txn(1'b1, 3'b010, 32'h0000_2000, 32'h0102_0304, 32'h0, 1'b0, 1);
    txn(1'b1, 3'b000, 32'h0000_2005, 32'h0000_0080, 32'h0, 1'b0, 3);
    txn(1'b0, 3'b000, 32'h0000_2005, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    txn(1'b0, 3'b100, 32'h0000_2005, 32'h0, 32'h0000_0080, 1'b0, 2);
    txn(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hDEAD_80EF, 1'b0, 2);
    txn(1'b0, 3'b000, 32'h0000_2007, 32'h0, 32'hFFFF_FFDE, 1'b0, 2);
    txn(1'b1, 3'b001, 32'h0000_2002, 32'hFFFF_8001, 32'h0, 1'b0, 3);
    txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h0000_8001, 1'b0, 2);
    txn(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h8001_0304, 1'b0, 2);

    // Faults: misaligned, out of range, illegal funct3; RAM must be untouched
    txn(1'b0, 3'b001, 32'h0000_2003, 32'h0, 32'h0, 1'b1, 1);
    txn(1'b1, 3'b010, 32'h0000_2002, 32'h1234_5678, 32'h0, 1'b1, 1);
    txn(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1);
    txn(1'b0, 3'b011, 32'h0000_2004, 32'h0, 32'h0, 1'b1, 1);
    txn(1'b1, 3'b100, 32'h0000_2004, 32'h5555_5555, 32'h0, 1'b1, 1);
    txn(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h8001_0304, 1'b0, 2);
    txn(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hDEAD_80EF, 1'b0, 2);

    // Output register
    issue(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0000_000F, 32'h0, 1'b0, 1, 1'b1, 1'b0);
    check("leds_after_sw", 32'({blue, green, red, led}), 32'hF);
    drain();
    txn(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0000_000F, 1'b0, 1);
    txn(1'b1, 3'b000, 32'hFFFF_FFFD, 32'h0000_0030, 32'h0, 1'b0, 1);
    txn(1'b0, 3'b100, 32'hFFFF_FFFC, 32'h0, 32'h0000_000F, 1'b0, 1);
    txn(1'b0, 3'b000, 32'hFFFF_FFFD, 32'h0, 32'h0, 1'b0, 1);
    txn(1'b1, 3'b010, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1);

    // Cycle counter: two reads exactly 10 cycles apart
    issue(1'b0, 3'b010, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b1);
    a1 = last_acc;
    drain();
    while (cyc < a1 + 10) begin
      @(negedge clk); #1;
    end
    issue(1'b0, 3'b010, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b1);
    check("cnt_spacing", 32'(last_acc - a1), 32'd10);
    drain();

    // Backpressure: response held stable, no new request accepted
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hDEAD_80EF, 1'b0, 2, 1'b1, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_rdata", resp_rdata, 32'hDEAD_80EF);
      check("stall_err", 32'(resp_err), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk); #1;
    end
    resp_ready = 1'b1;
    drain();

    // Reset while an sb sits in RMW_WR: write must be dropped, no response
    issue(1'b1, 3'b000, 32'h0000_2004, 32'h0000_0011, 32'h0, 1'b0, 3, 1'b0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #2;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_leds", 32'({blue, green, red, led}), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    rel_cyc = cyc;
    @(negedge clk); #2;
    check("abort_ready_after", 32'(req_ready), 32'd1);
    check("abort_valid_after", 32'(resp_valid), 32'd0);
    txn(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hDEAD_80EF, 1'b0, 2);
    txn(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1);

    repeat (3) @(negedge clk);
    #3;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
